// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback item type.
// XLEN   : integer data width
// NREG   : number of architectural registers
// REG_AW : register address width
// wb_item: one pending write, {rd, data}
package regfile_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_item;
endpackage

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// wb_fifo: parameterised synchronous FIFO used as the load-result queue.
// clk/rst  : clock, asynchronous active-high reset
// push_i   : write din_i (caller guarantees not full)
// pop_i    : advance head (caller guarantees not empty)
// dout_o   : current head entry
// count_o  : occupancy, 0..DEPTH
// empty_o  : count_o == 0
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU and load results onto the single
// register-file write port, with a pending-load scoreboard.
// alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake (ready is comb)
// ld_valid/ld_ready/ld_rd/ld_data     : load result handshake into the queue
// issue_valid/issue_rd                : load issue, marks rd busy
// rf_we/rf_rd/rf_wdata                : registered write toward the file
// busy                                : outstanding-load bit per register
// sb_err                              : sticky scoreboard consistency error
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREG-1:0]   busy,
  output logic              sb_err
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = REG_AW + XLEN;

  logic [CW-1:0]     lq_count;
  logic              lq_empty;
  logic [IW-1:0]     lq_head;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;
  logic              push, pop, alu_win, force_load;

  logic [SW-1:0]     starve_q, starve_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;

  assign {head_rd, head_data} = lq_head;

  // Full is judged on the registered count, so a full queue never pushes
  // in the same cycle it pops.
  assign ld_ready   = (lq_count < CW'(LQ_DEPTH));
  assign push       = ld_valid && ld_ready;
  assign force_load = !lq_empty && (starve_q == SW'(STARVE_LIMIT));
  assign alu_ready  = !force_load;
  assign alu_win    = alu_valid && alu_ready;
  assign pop        = !alu_win && !lq_empty;

  wb_fifo #(.WIDTH(IW), .DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({ld_rd, ld_data}),
    .pop_i   (pop),
    .dout_o  (lq_head),
    .count_o (lq_count),
    .empty_o (lq_empty)
  );

  always_comb begin
    we_d    = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (alu_win) begin
      we_d    = (alu_rd != ZERO_REG);
      rd_d    = alu_rd;
      wdata_d = alu_data;
    end else if (pop) begin
      we_d    = (head_rd != ZERO_REG);
      rd_d    = head_rd;
      wdata_d = head_data;
    end
  end

  // Counts ALU wins that bypass a waiting load; any pop or an empty queue
  // resets the fairness window.
  always_comb begin
    starve_d = starve_q;
    if (pop || lq_empty)
      starve_d = '0;
    else if (alu_win && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  // Clear is applied before set so a same-cycle issue to the retiring rd
  // leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (pop && head_rd != ZERO_REG) begin
      if (!busy_q[head_rd]) err_d = 1'b1;
      busy_d[head_rd] = 1'b0;
    end
    if (issue_valid && issue_rd != ZERO_REG) begin
      if (busy_q[issue_rd]) err_d = 1'b1;
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_rd    = rd_q;
  assign rf_wdata = wdata_q;
  assign busy     = busy_q;
  assign sb_err   = err_q;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  regfile_writeback_arbiter #(.LQ_DEPTH(4), .STARVE_LIMIT(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we"}, 64'(rf_we), 64'd1);
    chk({tag, ".rd"}, 64'(rf_rd), 64'(rd));
    chk({tag, ".data"}, 64'(rf_wdata), 64'(d));
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_valid = 0; issue_rd = 0;
    tick(); tick();
    chk("rst.we", 64'(rf_we), 0);
    chk("rst.rd", 64'(rf_rd), 0);
    chk("rst.wdata", 64'(rf_wdata), 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.err", 64'(sb_err), 0);
    chk("rst.ld_ready", 64'(ld_ready), 1);
    rst = 1'b0;
    tick();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    chk("alu.ready", 64'(alu_ready), 1);
    tick();
    alu_valid = 0;
    chk_wr("alu", 5'd5, 32'hDEADBEEF);
    chk("alu.ld_ready", 64'(ld_ready), 1);
    tick();
    chk("alu.idle_we", 64'(rf_we), 0);

    // Load path
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    chk("ld.busy_set", 64'(busy), 64'h80);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h12345678;
    tick();
    ld_valid = 0;
    chk("ld.push_no_we", 64'(rf_we), 0);
    chk("ld.busy_held", 64'(busy), 64'h80);
    tick();
    chk_wr("ld", 5'd7, 32'h12345678);
    chk("ld.busy_clr", 64'(busy), 0);
    chk("ld.err", 64'(sb_err), 0);
    tick();
    chk("ld.idle_we", 64'(rf_we), 0);

    // Starvation: one queued load vs a continuous ALU stream
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    ld_valid = 1; ld_rd = 9; ld_data = 32'hAAAA0009;
    tick();
    ld_valid = 0;
    alu_valid = 1; alu_rd = 10;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'(100 + i);
      chk($sformatf("starve.ready%0d", i), 64'(alu_ready), 1);
      tick();
      chk_wr($sformatf("starve.alu%0d", i), 5'd10, 32'(100 + i));
    end
    alu_data = 32'h200;
    chk("starve.forced", 64'(alu_ready), 0);
    tick();
    chk_wr("starve.load", 5'd9, 32'hAAAA0009);
    chk("starve.busy", 64'(busy), 0);
    chk("starve.ready_back", 64'(alu_ready), 1);
    tick();
    chk_wr("starve.alu_after", 5'd10, 32'h200);
    alu_valid = 0;
    tick();

    // Full / backpressure
    for (int r = 11; r <= 15; r++) begin
      issue_valid = 1; issue_rd = 5'(r);
      tick();
    end
    issue_valid = 0;
    alu_valid = 1; alu_rd = 20; alu_data = 32'h20;
    ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ld_rd = 5'(11 + i); ld_data = 32'(32'h1000 + 11 + i);
      chk($sformatf("full.ld_ready%0d", i), 64'(ld_ready), 1);
      tick();
      chk_wr($sformatf("full.alu%0d", i), 5'd20, 32'h20);
    end
    ld_rd = 15; ld_data = 32'h100F;
    chk("full.ld_ready_low", 64'(ld_ready), 0);
    chk("full.alu_ready", 64'(alu_ready), 1);
    tick();
    chk_wr("full.alu4", 5'd20, 32'h20);
    chk("full.still_full", 64'(ld_ready), 0);
    chk("full.forced", 64'(alu_ready), 0);
    tick();
    chk_wr("full.pop11", 5'd11, 32'h100B);
    chk("full.slot_free", 64'(ld_ready), 1);
    chk("full.alu_ready2", 64'(alu_ready), 1);
    tick();
    ld_valid = 0; alu_valid = 0;
    chk_wr("full.alu5", 5'd20, 32'h20);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_wr($sformatf("full.drain%0d", j), 5'(12 + j), 32'(32'h1000 + 12 + j));
    end
    chk("full.busy", 64'(busy), 0);
    chk("full.err", 64'(sb_err), 0);
    tick();
    chk("full.empty_we", 64'(rf_we), 0);

    // x0 write is consumed but suppressed
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    chk("x0.ready", 64'(alu_ready), 1);
    tick();
    alu_valid = 0;
    chk("x0.we", 64'(rf_we), 0);

    // Double issue error, sticky
    issue_valid = 1; issue_rd = 3;
    tick();
    chk("err.first", 64'(sb_err), 0);
    tick();
    issue_valid = 0;
    chk("err.set", 64'(sb_err), 1);
    chk("err.busy", 64'(busy), 64'h8);
    tick();
    chk("err.sticky", 64'(sb_err), 1);

    // Reset with two loads queued while ALU keeps writing
    issue_valid = 1; issue_rd = 21;
    tick();
    issue_rd = 22;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 25; alu_data = 32'h25;
    ld_valid = 1; ld_rd = 21; ld_data = 32'h21;
    tick();
    ld_rd = 22; ld_data = 32'h22;
    tick();
    ld_valid = 0;
    chk("rstmid.pre_we", 64'(rf_we), 1);
    chk("rstmid.pre_busy", 64'(busy), 64'h0060_0008);
    rst = 1'b1;
    #1;
    chk("rstmid.we", 64'(rf_we), 0);
    chk("rstmid.busy", 64'(busy), 0);
    chk("rstmid.err", 64'(sb_err), 0);
    alu_valid = 0;
    tick();
    rst = 1'b0;
    chk("rstmid.ld_ready", 64'(ld_ready), 1);
    tick();
    chk("rstmid.no_stale", 64'(rf_we), 0);
    tick();
    chk("rstmid.no_stale2", 64'(rf_we), 0);
    alu_valid = 1; alu_rd = 26; alu_data = 32'h26;
    tick();
    alu_valid = 0;
    chk_wr("rstmid.new", 5'd26, 32'h26);
    tick();
    chk("rstmid.after_we", 64'(rf_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Write-side front end of the 32x32 integer register file: merges results from the single-cycle ALU path and the multi-cycle load unit into the file's single write port.
- Drives one registered write per cycle (we/rd/wdata) toward the register file.
- Keeps a pending-load scoreboard so decode can stall on RAW hazards against in-flight loads.

Parameters:
- LQ_DEPTH, 4, load-result queue depth (power of 2, >=2)
- STARVE_LIMIT, 4, max consecutive ALU wins while the load queue is non-empty before a load write is forced
- XLEN, 32, data width
- Shared constants (not per-instance parameters): NREG = 32 registers, REG_AW = 5 address bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result present
- ld_ready  out  1  load queue not full (combinational from queue count)
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load result
- issue_valid  in  1  a load issued this cycle (sets scoreboard)
- issue_rd  in  5  destination of the issued load
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- busy  out  32  scoreboard: bit n = load to xn outstanding (bit 0 always 0)
- sb_err  out  1  sticky: issue to an already-busy rd, or load return to a non-busy rd

Behaviour:
- Reset (async): rf_we=0, rf_rd=0, rf_wdata=0, busy=0, sb_err=0, queue empty, starve counter=0.
- Load queue: FIFO of {rd, data}, LQ_DEPTH entries.
  - Push when ld_valid && ld_ready. ld_ready = count < LQ_DEPTH, so push while full is impossible.
  - Pointers wrap modulo LQ_DEPTH; count has log2(LQ_DEPTH)+1 bits.
  - Push and pop in the same cycle when full is legal only as pop-then-push: ld_ready stays low when full, so no push occurs that cycle.
- force_load = (queue non-empty) && (starve_cnt == STARVE_LIMIT).
- alu_ready = !force_load.
- Selection each cycle:
  - alu_valid && alu_ready: ALU wins.
  - Otherwise, queue non-empty: pop the head.
  - Otherwise: no write.
- Latency: the selected item appears on rf_we/rf_rd/rf_wdata on the next clk edge. Exactly one cycle, no bypass.
- x0: a selected item with rd==0 is consumed (ALU accepted / queue popped), but rf_we=0 for that cycle.
- Starve counter:
  - Increments when the ALU wins and the queue is non-empty, saturating at STARVE_LIMIT.
  - Clears on any pop, or whenever the queue is empty.
- Scoreboard:
  - Set busy[issue_rd] on issue_valid (issue_rd != 0).
  - Clear busy[rd] when that load's write is emitted into the rf_* registers.
  - Same-cycle set and clear of the same bit: set wins.
  - Issue to an already-busy rd: busy stays 1 and sb_err is set.
  - Load popped with busy[rd]==0: write still performed, sb_err set.
  - Upstream guarantees at most one outstanding load per rd; decode stalls on busy.
- Ordering: load results retire in arrival order. ALU vs load ordering is by arbitration only; WAW is excluded by the decode stall.
- Reset mid-operation: queued results are discarded, busy is cleared, and any in-progress rf_we drops immediately.

Decomposition:
- Package regfile_pkg holds:
  - XLEN, NREG = 32, REG_AW = 5
  - wb_item typedef {rd[4:0], data[XLEN-1:0]}
  - the ZERO_REG constant
- One sub-module: wb_fifo (parameterised sync FIFO with count, push/pop, full/empty), instantiated as the load queue.

Test Plan:
- ALU only: alu_valid with rd=5, data=0xDEADBEEF → next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; queue untouched.
- Load path:
  - Stimulus: issue_rd=7, then ld_valid with rd=7, data=0x12345678, ALU idle.
  - Required response: busy[7]=1 from the cycle after issue; rf_* shows the load 2 cycles after ld_valid (queue push, then pop and register); busy[7]=0 in the same cycle rf_we asserts.
- Starvation:
  - Stimulus: queue holds 1 entry, alu_valid held high, STARVE_LIMIT=4.
  - Required response: 4 consecutive ALU writes; then alu_ready=0 for one cycle while the load is written; alu_ready returns to 1 on the next cycle.
- Full/backpressure:
  - Stimulus: 4 loads pushed while ALU is valid every cycle.
  - Required response: ld_ready=0 at count=4; a 5th ld_valid is held, not lost; it is accepted once a pop frees a slot; write order matches arrival order.
- x0:
  - Stimulus: ALU write to rd=0, data=0xFFFFFFFF.
  - Required response: alu_ready=1, rf_we=0 next cycle.
- Errors and reset:
  - Stimulus: issue_rd=3 twice without a return; separately, assert rst with 2 entries queued.
  - Required response: sb_err=1 after the second issue and stays set; rst clears rf_we, busy, queue and sb_err asynchronously; the first write after reset comes only from new input.
